// File: rtl/shift_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_pkg : op and state encodings shared by shift_seq blocks    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package shift_seq_pkg;

   localparam logic [1:0] OP_SHL = 2'b00;
   localparam logic [1:0] OP_SHR = 2'b01;
   localparam logic [1:0] OP_SAR = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_step : combinational one-bit shift selected by op              |
// | Rotate support only when SHIFT_SEQ_ROTATE_EN is defined.  Rev 1.0    |
// +----------------------------------------------------------------------+
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (op_i)
         OP_SHL: data_o = {data_i[WIDTH-2:0], 1'b0};
         OP_SHR: data_o = {1'b0, data_i[WIDTH-1:1]};
         OP_SAR: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
         OP_ROR: data_o = {data_i[0], data_i[WIDTH-1:1]};
`endif
         default: data_o = data_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq : iterative one-bit-per-clock shifter with valid/ready I/O |
// | Op 11 rotates when SHIFT_SEQ_ROTATE_EN is defined. Rev 1.0           |
// +----------------------------------------------------------------------+
module shift_seq
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] w_step;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data_i (work_q),
      .op_i   (op_q),
      .data_o (w_step)
   );

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      out_data_d = out_data_q;
      count_d    = count_q;
      op_d       = op_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d = in_data;
               op_d   = in_op;
`ifdef SHIFT_SEQ_ROTATE_EN
               count_d = in_amt;
`else
               // Without rotate support op 11 is a zero-latency pass-through.
               count_d = (in_op == OP_ROR) ? '0 : in_amt;
`endif
               if (count_d == '0) begin
                  state_d    = ST_DONE;
                  out_data_d = in_data;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            work_d  = w_step;
            count_d = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) begin
               state_d    = ST_DONE;
               out_data_d = w_step;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         work_q     <= '0;
         out_data_q <= '0;
         count_q    <= '0;
         op_q       <= OP_SHL;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         out_data_q <= out_data_d;
         count_q    <= count_d;
         op_q       <= op_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_seq : directed table, corner sequences and random checks    |
// | Honours SHIFT_SEQ_ROTATE_EN for op 11 expectations. Rev 1.0          |
// +----------------------------------------------------------------------+
module tb_shift_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  in_op = '0;
   logic [3:0]  in_amt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference: whole-distance shift expressed with plain operators.
   function automatic logic [15:0] ref_result(input logic [15:0] d, input logic [1:0] op,
                                               input logic [3:0] a);
      logic [31:0] dd;
      case (op)
         2'b00:   return d << a;
         2'b01:   return d >> a;
         2'b10:   return 16'($signed(d) >>> a);
         default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
            dd = {d, d} >> a;
            return dd[15:0];
`else
            dd = {16'h0, d};
            return dd[15:0];
`endif
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [3:0] a);
`ifdef SHIFT_SEQ_ROTATE_EN
      return int'(a);
`else
      return (op == 2'b11) ? 0 : int'(a);
`endif
   endfunction

   task automatic do_op(input logic [15:0] d, input logic [1:0] op, input logic [3:0] a,
                        input logic [15:0] exp, input int exp_lat, input string name);
      int lat;
      lat = 0;
      @(negedge clk);
      chk({name, " in_ready before"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = d; in_op = op; in_amt = a;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = 16'($urandom); in_op = 2'($urandom); in_amt = 4'($urandom);
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " out_data"}, 32'(out_data), 32'(exp));
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
      chk({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
      chk({name, " out_data held"}, 32'(out_data), 32'(exp));
   endtask

   initial begin
      int wait_n;
      logic [15:0] rd;
      logic [1:0]  rop;
      logic [3:0]  ra;

      tbl[0] = '{16'h0001, 2'b00, 4'd1,  16'h0002, 1};
      tbl[1] = '{16'h000F, 2'b00, 4'd15, 16'h8000, 15};
      tbl[2] = '{16'h000F, 2'b01, 4'd0,  16'h000F, 0};
      tbl[3] = '{16'h8000, 2'b10, 4'd2,  16'hE000, 2};
      tbl[4] = '{16'h8000, 2'b01, 4'd2,  16'h2000, 2};
      tbl[5] = '{16'h7FFF, 2'b10, 4'd3,  16'h0FFF, 3};
`ifdef SHIFT_SEQ_ROTATE_EN
      tbl[6] = '{16'h0002, 2'b11, 4'd2,  16'h8000, 2};
      tbl[7] = '{16'h0001, 2'b11, 4'd1,  16'h8000, 1};
`else
      tbl[6] = '{16'h0002, 2'b11, 4'd2,  16'h0002, 0};
      tbl[7] = '{16'h0001, 2'b11, 4'd1,  16'h0001, 0};
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'h0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_op(tbl[i].data, tbl[i].op, tbl[i].amt, tbl[i].exp, tbl[i].lat,
               $sformatf("tbl%0d", i));
      end

      // Backpressure with ignored second request
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h00F0; in_op = 2'b00; in_amt = 4'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_n = 0;
      while (!out_valid && wait_n < 40) begin
         @(posedge clk); #1;
         wait_n++;
      end
      chk("bp latency", 32'(wait_n), 32'd4);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'hAAAA; in_op = 2'b01; in_amt = 4'd0;
         @(posedge clk); #1;
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp out_data", 32'(out_data), 32'h0F00);
         chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp delivered once", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp no second op", 32'({out_valid, busy}), 32'd0);
         chk("bp data kept", 32'(out_data), 32'h0F00);
      end

      // Reset in the middle of a long shift
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h1234; in_op = 2'b01; in_amt = 4'd10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid busy before reset", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid rst in_ready", 32'(in_ready), 32'd1);
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst out_data", 32'(out_data), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("mid no out_valid", 32'(out_valid), 32'd0);
      end
      do_op(16'h1234, 2'b01, 4'd4, 16'h0123, 4, "after reset");

      // Random operations against the reference model
      for (int i = 0; i < 60; i++) begin
         rd  = 16'($urandom);
         rop = 2'($urandom);
         ra  = 4'($urandom);
         do_op(rd, rop, ra, ref_result(rd, rop, ra), ref_lat(rop, ra),
               $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Iterative shift controller that sequences the 16-bit data register path one bit position per clock. It accepts a shift request (data, operation, amount) over a valid/ready handshake, performs the shift over `amt` cycles, and presents the result over a second valid/ready handshake. It sits between the CPU's operand path and writeback, and replaces a barrel shifter with a small counter-driven state machine.

## Interface
- `WIDTH`, 16, datapath width in bits
- `AMT_W`, 4, shift-amount width; maximum shift is 2^AMT_W − 1
---
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  controller can accept a request
- `in_data`  in  WIDTH  operand
- `in_op`  in  2  00 SHL, 01 SHR (logical), 10 SAR (arithmetic), 11 ROR (see Configuration)
- `in_amt`  in  AMT_W  shift distance
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  WIDTH  shifted result
- `busy`  out  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Reset state: IDLE.
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `in_ready`=1. Internal count and op are cleared.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch the data into the work register, latch op, and set count=`in_amt`. Next state is DONE if `in_amt`==0, else SHIFT.
- SHIFT: each cycle applies a one-bit shift to the work register and decrements count. The state moves to DONE on the edge where count goes from 1 to 0.
- One-bit shift rules:
  - SHL inserts 0 at bit 0.
  - SHR inserts 0 at the MSB.
  - SAR replicates the MSB.
  - ROR moves bit 0 into the MSB.
- DONE: `out_valid`=1 and `out_data` = work register. On `out_ready`, the state returns to IDLE.
- `in_ready`=0 in SHIFT and DONE. `in_valid` is ignored there, and the request is not queued.
- `out_data` holds its last value in all states and changes only when DONE is entered.
- `in_data`, `in_op` and `in_amt` are sampled only at the accept edge. Later changes have no effect.

## Timing
- Accept at edge E. `out_valid` rises after edge E+1+`in_amt`−1. For `amt`=0, it is visible in the cycle after E.
- Example: `amt`=3 gives `out_valid` high 3 cycles after the accept edge.
- Throughput: one operation per `amt`+2 cycles when `out_ready` is held high. There is no IDLE bypass: `in_ready` rises the cycle after the output handshake.
- Backpressure: `out_valid` and `out_data` stay stable until `out_ready` is sampled high.
- Reset asserted mid-operation clears state, outputs and count immediately (asynchronously). The in-flight operation is lost and produces no output.
- Reset deassertion is synchronised externally; the first accept can occur at the first edge after release.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined: op 11 performs rotate-right by `amt`.
- Macro not defined:
  - op 11 is a pass-through; the result is `in_data` unchanged.
  - Count is forced to 0, so the state goes straight to DONE with `amt`=0 latency.
  - The ROR logic is absent from the netlist.

## Structure
- Shared package `shift_seq_pkg` holds:
  - op encodings `OP_SHL`, `OP_SHR`, `OP_SAR`, `OP_ROR`
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`
- Sub-module `shift_step`: combinational one-bit shift of WIDTH bits selected by op. It is instantiated once inside `shift_seq`. ROR inside it is guarded by the same macro.

## Test plan
1. Reset held low, then released → `in_ready`=1, `out_valid`=0, `out_data`=0x0000, `busy`=0.
2. Basic shifts:
   - 0x0001 SHL amt 1 → `out_data`=0x0002, `out_valid` in the 2nd cycle after accept.
   - 0x000F SHL 15 → 0x8000.
   - 0x000F amt 0 → 0x000F in the cycle after accept.
3. Signed vs. unsigned right shift:
   - 0x8000 SAR 2 → 0xE000.
   - 0x8000 SHR 2 → 0x2000.
   - 0x7FFF SAR 3 → 0x0FFF.
4. Backpressure: hold `out_ready`=0 for 5 cycles after DONE, and pulse `in_valid` with new data during that time. Required: `out_data` stable, `in_ready`=0, second request not accepted, result delivered once on `out_ready`.
5. Reset mid-SHIFT: request 0x1234 SHR 10, assert `rst` low after 3 cycles. Required: outputs at reset values immediately, no `out_valid`. After release, 0x1234 SHR 4 → 0x0123.
6. Op 11, with and without the macro:
   - With `SHIFT_SEQ_ROTATE_EN`: 0x0002 ROR 2 → 0x8000; 0x0001 ROR 1 → 0x8000.
   - Without: 0x0002 op 11 amt 2 → 0x0002 in the cycle after accept.
